ultrasonic_scan_scheduler: RTL and testbench

ULTRASONIC_SCAN_SCHEDULER -- requirements
Module: ultrasonic_scan_scheduler

---
 rtl/ultrasonic_pkg.sv | 23 ++
 rtl/ultrasonic_echo_timer.sv | 48 ++++
 rtl/ultrasonic_scan_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_ultrasonic_scan_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic scan scheduler.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        GUARD     = 3'd4
    } scan_state_e;

    localparam logic [15:0] ADDR_DIST_BASE = 16'h0900;
    localparam logic [15:0] ADDR_VALID     = 16'h0920;
    localparam logic [15:0] ADDR_TIMEOUT   = 16'h0924;
    localparam logic [15:0] ADDR_IDX       = 16'h0928;
    localparam logic [15:0] ADDR_STATE     = 16'h092C;
    localparam logic [15:0] DIST_TIMEOUT   = 16'hFFFF;

    function automatic logic [15:0] dist_addr(input int unsigned i);
        return ADDR_DIST_BASE + 16'(4 * i);
    endfunction

endpackage

// File: rtl/ultrasonic_echo_timer.sv
// Echo-width timer: prescaler of CYCLES_PER_CM cycles feeding a cm counter saturating at MAX_CM.
module ultrasonic_echo_timer #(
    parameter int unsigned CYCLES_PER_CM = 2900,
    parameter int unsigned MAX_CM        = 400
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        clear,
    input  logic        run,
    output logic [15:0] cm_count,
    output logic        at_max
);

    localparam int unsigned PW = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   cm_q, cm_d;

    always_comb begin
        presc_d = presc_q;
        cm_d    = cm_q;
        if (clear) begin
            presc_d = '0;
            cm_d    = '0;
        end else if (run) begin
            if (presc_q == PW'(CYCLES_PER_CM - 1)) begin
                presc_d = '0;
                if (cm_q != 16'(MAX_CM)) cm_d = cm_q + 16'd1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            presc_q <= '0;
            cm_q    <= '0;
        end else begin
            presc_q <= presc_d;
            cm_q    <= cm_d;
        end
    end

    assign cm_count = cm_q;
    assign at_max   = (cm_q == 16'(MAX_CM));

endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin ultrasonic ranger scheduler with bus-readable results.
// Optional ULTRASONIC_IRQ_EN adds a registered irq output (OR of valid bits).
module ultrasonic_scan_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int unsigned NUM_SENSORS   = 4,
    parameter int unsigned CYCLES_PER_CM = 2900,
    parameter int unsigned TRIG_CYCLES   = 500,
    parameter int unsigned RISE_TIMEOUT  = 25000,
    parameter int unsigned MAX_CM        = 400,
    parameter int unsigned GUARD_CYCLES  = 500000
) (
    input  logic                   clk,
    input  logic                   reset_l,
    input  logic                   enable,
    input  logic                   io_select,
    input  logic [15:0]            address,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trigger,
    output logic [15:0]            read_data
`ifdef ULTRASONIC_IRQ_EN
    ,
    output logic                   irq
`endif
);

    localparam int unsigned CNT_MAX0 = (TRIG_CYCLES > RISE_TIMEOUT) ? TRIG_CYCLES : RISE_TIMEOUT;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > GUARD_CYCLES) ? CNT_MAX0 : GUARD_CYCLES;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);

    scan_state_e            state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d, idx_nxt;
    logic [NUM_SENSORS-1:0] trig_q, trig_d;
    logic [NUM_SENSORS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [NUM_SENSORS-1:0] valid_q, valid_d, timeout_q, timeout_d;
    logic [15:0]            dist_q [NUM_SENSORS];
    logic [15:0]            dist_d [NUM_SENSORS];

    logic [NUM_SENSORS-1:0] sel, clr;
    logic                   echo_cur, echo_rise, done, res_to, tmr_clear, tmr_run, at_max;
    logic [15:0]            res_dist, cm_count;

    ultrasonic_echo_timer #(
        .CYCLES_PER_CM(CYCLES_PER_CM),
        .MAX_CM       (MAX_CM)
    ) u_timer (
        .clk     (clk),
        .reset_l (reset_l),
        .clear   (tmr_clear),
        .run     (tmr_run),
        .cm_count(cm_count),
        .at_max  (at_max)
    );

    always_comb begin
        sync1_d   = echo;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        sel       = NUM_SENSORS'(1) << idx_q;
        echo_cur  = |(sync2_q & sel);
        echo_rise = |(sync2_q & ~sync3_q & sel);
        idx_nxt   = (idx_q == 3'(NUM_SENSORS - 1)) ? 3'd0 : idx_q + 3'd1;

        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        trig_d    = trig_q;
        done      = 1'b0;
        res_dist  = cm_count;
        res_to    = 1'b0;
        tmr_clear = 1'b1;
        tmr_run   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = TRIG;
                    cnt_d   = '0;
                    trig_d  = sel;
                end
            end
            TRIG: begin
                if (cnt_q == CW'(TRIG_CYCLES - 1)) begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                    trig_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    // The rise cycle itself counts toward the echo width.
                    state_d   = MEASURE;
                    cnt_d     = '0;
                    tmr_clear = 1'b0;
                    tmr_run   = 1'b1;
                end else if (cnt_q == CW'(RISE_TIMEOUT - 1)) begin
                    state_d  = GUARD;
                    cnt_d    = '0;
                    done     = 1'b1;
                    res_dist = DIST_TIMEOUT;
                    res_to   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MEASURE: begin
                tmr_clear = 1'b0;
                if (!echo_cur) begin
                    state_d = GUARD;
                    done    = 1'b1;
                end else if (at_max) begin
                    state_d  = GUARD;
                    done     = 1'b1;
                    res_dist = DIST_TIMEOUT;
                    res_to   = 1'b1;
                end else begin
                    tmr_run = 1'b1;
                end
            end
            GUARD: begin
                if (cnt_q == CW'(GUARD_CYCLES - 1)) begin
                    cnt_d = '0;
                    idx_d = idx_nxt;
                    if (enable) begin
                        state_d = TRIG;
                        trig_d  = NUM_SENSORS'(1) << idx_nxt;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                trig_d  = '0;
            end
        endcase

        for (int i = 0; i < NUM_SENSORS; i++) begin
            clr[i]    = io_select && (address == dist_addr(i));
            dist_d[i] = dist_q[i];
            if (done && sel[i]) dist_d[i] = res_dist;
        end
        // A completion setting valid overrides a coincident read clearing it.
        valid_d   = (valid_q & ~clr) | (done ? sel : '0);
        timeout_d = done ? ((timeout_q & ~sel) | (res_to ? sel : '0)) : timeout_q;
    end

    always_comb begin
        read_data = '0;
        if (io_select) begin
            if (address == ADDR_VALID)   read_data = 16'(valid_q);
            if (address == ADDR_TIMEOUT) read_data = 16'(timeout_q);
            if (address == ADDR_IDX)     read_data = {13'b0, idx_q};
            if (address == ADDR_STATE)   read_data = {13'b0, state_q};
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (address == dist_addr(i)) read_data = dist_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            trig_q    <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            valid_q   <= '0;
            timeout_q <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) dist_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            trig_q    <= trig_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            for (int i = 0; i < NUM_SENSORS; i++) dist_q[i] <= dist_d[i];
        end
    end

    assign trigger = trig_q;

`ifdef ULTRASONIC_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = |valid_q;
    always_ff @(posedge clk) begin
        if (!reset_l) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end
    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Self-checking bench for ultrasonic_scan_scheduler with scaled-down timing parameters.
module tb_ultrasonic_scan_scheduler;
    import ultrasonic_pkg::*;

    localparam int unsigned NS  = 4;
    localparam int unsigned CPC = 10;
    localparam int unsigned TC  = 20;
    localparam int unsigned RT  = 200;
    localparam int unsigned MC  = 40;
    localparam int unsigned GC  = 100;

    logic          clk       = 1'b0;
    logic          reset_l   = 1'b0;
    logic          enable    = 1'b0;
    logic          io_select = 1'b0;
    logic [15:0]   address   = 16'h0000;
    logic [NS-1:0] echo      = '0;
    logic [NS-1:0] echo_drv  = '0;
    logic [NS-1:0] trigger;
    logic [15:0]   read_data;
`ifdef ULTRASONIC_IRQ_EN
    logic          irq;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    int            exp_idx = 0;
    logic [15:0]   m_dist [NS];
    logic [NS-1:0] m_valid = '0;
    logic [NS-1:0] m_to    = '0;
    logic [15:0]   rd;

    ultrasonic_scan_scheduler #(
        .NUM_SENSORS  (NS),
        .CYCLES_PER_CM(CPC),
        .TRIG_CYCLES  (TC),
        .RISE_TIMEOUT (RT),
        .MAX_CM       (MC),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk      (clk),
        .reset_l  (reset_l),
        .enable   (enable),
        .io_select(io_select),
        .address  (address),
        .echo     (echo),
        .trigger  (trigger),
        .read_data(read_data)
`ifdef ULTRASONIC_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc_rd(input logic [15:0] a, input logic s);
        @(negedge clk);
        echo      = echo_drv;
        address   = a;
        io_select = s;
        #1;
        rd = read_data;
    endtask

    task automatic model_clear();
        exp_idx = 0;
        m_valid = '0;
        m_to    = '0;
        for (int i = 0; i < NS; i++) m_dist[i] = 16'h0000;
    endtask

    task automatic check_all_zero(input string tag);
        cyc_rd(ADDR_STATE, 1'b1);
        n_tests++;
        if (trigger !== '0 || rd !== 16'(IDLE)) begin
            n_fail++;
            $display("FAIL %s_state: trigger=%b state=%0d required trigger=0 state=%0d",
                     tag, trigger, rd, IDLE);
        end
        cyc_rd(ADDR_VALID, 1'b1);
        n_tests++;
        if (rd !== 16'h0000) begin
            n_fail++; $display("FAIL %s_valid: got %h required 0000", tag, rd);
        end
        cyc_rd(ADDR_TIMEOUT, 1'b1);
        n_tests++;
        if (rd !== 16'h0000) begin
            n_fail++; $display("FAIL %s_timeout: got %h required 0000", tag, rd);
        end
        cyc_rd(ADDR_IDX, 1'b1);
        n_tests++;
        if (rd !== 16'h0000) begin
            n_fail++; $display("FAIL %s_idx: got %h required 0000", tag, rd);
        end
        for (int i = 0; i < NS; i++) begin
            cyc_rd(dist_addr(i), 1'b1);
            n_tests++;
            if (rd !== 16'h0000) begin
                n_fail++; $display("FAIL %s_dist%0d: got %h required 0000", tag, i, rd);
            end
        end
    endtask

    // One full sensor slot. mode 0: echo pulse of h cycles starting d cycles after the
    // trigger falls; mode 1: no echo at all.
    task automatic run_sensor(input int mode, input int d, input int h,
                              input bit collide, input bit drop_en);
        int          n, w, cyc, gn, e_cyc;
        bit          done;
        logic [15:0] e_dist;
        logic        e_to;

        if (mode == 1) begin
            e_dist = DIST_TIMEOUT; e_to = 1'b1; e_cyc = RT;
        end else if (h > int'(MC * CPC)) begin
            e_dist = DIST_TIMEOUT; e_to = 1'b1; e_cyc = d + 3 + int'(MC * CPC);
        end else begin
            e_dist = 16'(h / CPC); e_to = 1'b0; e_cyc = d + h + 3;
        end

        n = 0;
        while (trigger == '0 && n < int'(2 * GC + 50)) begin
            cyc_rd(ADDR_STATE, 1'b1);
            n++;
        end
        w = 0;
        while (trigger != '0 && w < int'(2 * TC)) begin
            n_tests++;
            if (trigger !== (NS'(1) << exp_idx)) begin
                n_fail++;
                $display("FAIL trigger_sel: trigger=%b required=%b", trigger, NS'(1) << exp_idx);
            end
            w++;
            cyc_rd(ADDR_STATE, 1'b1);
        end
        n_tests++;
        if (w != int'(TC)) begin
            n_fail++; $display("FAIL trigger_width: got %0d cycles required %0d", w, TC);
        end

        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < int'(RT + MC * CPC + 100)) begin
            cyc++;
            if (drop_en && cyc == 1) enable = 1'b0;
            echo_drv = (mode == 0 && cyc >= d && cyc < d + h) ? (NS'(1) << exp_idx) : '0;
            if (collide && cyc == d + h + 2) begin
                cyc_rd(dist_addr(exp_idx), 1'b1);
            end else begin
                cyc_rd(ADDR_STATE, 1'b1);
                if (rd == 16'(GUARD)) done = 1'b1;
            end
            n_tests++;
            if (trigger !== '0) begin
                n_fail++; $display("FAIL trigger_idle: trigger=%b required 0", trigger);
            end
        end
        echo_drv = '0;
        n_tests++;
        if (!done || cyc != e_cyc) begin
            n_fail++;
            $display("FAIL done_cycle: reached=%0d cycle=%0d required cycle=%0d", done, cyc, e_cyc);
        end

        m_dist[exp_idx]  = e_dist;
        m_to[exp_idx]    = e_to;
        m_valid[exp_idx] = 1'b1;

        gn = 1;
        cyc_rd(ADDR_VALID, 1'b1);
        gn++;
        n_tests++;
        if (rd !== 16'(m_valid)) begin
            n_fail++; $display("FAIL valid_bits: got %h required %h", rd, 16'(m_valid));
        end
        cyc_rd(ADDR_TIMEOUT, 1'b1);
        gn++;
        n_tests++;
        if (rd !== 16'(m_to)) begin
            n_fail++; $display("FAIL timeout_bits: got %h required %h", rd, 16'(m_to));
        end
        cyc_rd(dist_addr(exp_idx), 1'b1);
        gn++;
        m_valid[exp_idx] = 1'b0;
        n_tests++;
        if (rd !== e_dist) begin
            n_fail++; $display("FAIL distance%0d: got %h required %h", exp_idx, rd, e_dist);
        end

        n = 0;
        cyc_rd(ADDR_STATE, 1'b1);
        while (rd == 16'(GUARD) && n < int'(2 * GC)) begin
            gn++;
            n++;
            cyc_rd(ADDR_STATE, 1'b1);
        end
        n_tests++;
        if (gn != int'(GC)) begin
            n_fail++; $display("FAIL guard_len: got %0d cycles required %0d", gn, GC);
        end
        exp_idx = (exp_idx + 1) % NS;
        n_tests++;
        if (rd !== (enable ? 16'(TRIG) : 16'(IDLE))) begin
            n_fail++;
            $display("FAIL post_guard_state: got %0d required %0d", rd, enable ? TRIG : IDLE);
        end
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        enable  = 1'b0;
        repeat (3) cyc_rd(ADDR_STATE, 1'b1);
        model_clear();
        check_all_zero("reset");
        reset_l = 1'b1;
    endtask

    task automatic test_basic();
        enable = 1'b1;
        run_sensor(0, 50, 100, 1'b0, 1'b0);
    endtask

    task automatic test_rise_timeout();
        run_sensor(1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_max_cm();
        run_sensor(0, 7, int'(MC * CPC) + 60, 1'b0, 1'b0);
    endtask

    task automatic test_max_boundary();
        run_sensor(0, 3, int'(MC * CPC), 1'b0, 1'b0);
    endtask

    task automatic test_read_collision();
        run_sensor(0, 5, 33, 1'b1, 1'b1);
        cyc_rd(ADDR_VALID, 1'b1);
        n_tests++;
        if (rd[0] !== 1'b0) begin
            n_fail++; $display("FAIL collision_later_clear: valid0=%b required 0", rd[0]);
        end
    endtask

    task automatic test_bus();
        cyc_rd(dist_addr(0), 1'b0);
        n_tests++;
        if (rd !== 16'h0000) begin
            n_fail++; $display("FAIL bus_deselect: got %h required 0000", rd);
        end
        cyc_rd(16'h0930, 1'b1);
        n_tests++;
        if (rd !== 16'h0000) begin
            n_fail++; $display("FAIL bus_unmapped: got %h required 0000", rd);
        end
        cyc_rd(16'h0902, 1'b1);
        n_tests++;
        if (rd !== 16'h0000) begin
            n_fail++; $display("FAIL bus_misaligned: got %h required 0000", rd);
        end
        for (int i = 0; i < NS; i++) begin
            cyc_rd(dist_addr(i), 1'b1);
            n_tests++;
            if (rd !== m_dist[i]) begin
                n_fail++; $display("FAIL bus_dist%0d: got %h required %h", i, rd, m_dist[i]);
            end
        end
        cyc_rd(ADDR_IDX, 1'b1);
        n_tests++;
        if (rd !== 16'(exp_idx)) begin
            n_fail++; $display("FAIL bus_idx: got %h required %h", rd, 16'(exp_idx));
        end
    endtask

    task automatic test_enable_stop();
        int hits;
        enable = 1'b1;
        run_sensor(0, 20, 57, 1'b0, 1'b1);
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            cyc_rd(ADDR_IDX, 1'b1);
            if (trigger !== '0) hits++;
        end
        n_tests++;
        if (hits != 0 || rd !== 16'(exp_idx)) begin
            n_fail++;
            $display("FAIL enable_stop: trigger_cycles=%0d idx=%0d required 0 and idx=%0d",
                     hits, rd, exp_idx);
        end
    endtask

    task automatic test_random();
        int mode, d, h;
        enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            mode = $urandom_range(0, 3);
            d    = $urandom_range(1, RT - 10);
            case (mode)
                0, 1:    h = $urandom_range(1, MC * CPC);
                2:       h = $urandom_range(MC * CPC + 1, MC * CPC + 40);
                default: h = 0;
            endcase
            run_sensor((mode == 3) ? 1 : 0, d, h, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_measure();
        int  n;
        bit  hit;
        n = 0;
        while (trigger == '0 && n < 500) begin cyc_rd(ADDR_STATE, 1'b1); n++; end
        n = 0;
        while (trigger != '0 && n < 500) begin cyc_rd(ADDR_STATE, 1'b1); n++; end
        echo_drv = NS'(1) << exp_idx;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 50) begin
            cyc_rd(ADDR_STATE, 1'b1);
            if (rd == 16'(MEASURE)) hit = 1'b1;
            n++;
        end
        n_tests++;
        if (!hit) begin
            n_fail++; $display("FAIL reach_measure: got state %0d required %0d", rd, MEASURE);
        end
        reset_l  = 1'b0;
        enable   = 1'b0;
        echo_drv = '0;
        model_clear();
        check_all_zero("rst_meas");
        reset_l = 1'b1;
    endtask

    task automatic test_reset_trig();
        enable = 1'b1;
        run_sensor(0, 10, 45, 1'b0, 1'b0);
        repeat (3) cyc_rd(ADDR_STATE, 1'b1);
        n_tests++;
        if (trigger !== 4'b0010) begin
            n_fail++; $display("FAIL trig_before_reset: trigger=%b required 0010", trigger);
        end
        reset_l = 1'b0;
        enable  = 1'b0;
        model_clear();
        check_all_zero("rst_trig");
        reset_l = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) m_dist[i] = 16'h0000;
        test_reset();
        test_basic();
        test_rise_timeout();
        test_max_cm();
        test_max_boundary();
        test_read_collision();
        test_bus();
        test_enable_stop();
        test_random();
        test_bus();
        test_reset_measure();
        test_reset_trig();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
